// File: rtl/gen_pipe.sv
// rtl/gen_pipe.sv - multi-lane elastic delay pipeline with flush, lane reversal and occupancy count
//
// Purpose: moves a LANES x LANE_W beat through DEPTH register stages with
// valid/ready backpressure. Bubbles collapse, so a beat moves forward whenever
// the next stage is empty or emptying. Lane reversal is applied on entry.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   pipeline accepts the input beat this cycle
//   in_data    input beat, lane k = bits [k*LANE_W +: LANE_W]
//   in_rev     reverse lane order of the accepted beat
//   flush      synchronous clear of all stages
//   out_valid  output beat valid
//   out_ready  consumer accepts the output beat
//   out_data   output beat
//   count      number of occupied stages, 0..DEPTH

module gen_pipe #(
  parameter  int LANES  = 4,
  parameter  int LANE_W = 1,
  parameter  int DEPTH  = 2,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic                    in_rev,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [CW-1:0]           count
);

  localparam int W = LANES * LANE_W;

  logic [DEPTH-1:0] v_q, v_d;
  logic [W-1:0]     d_q [DEPTH];
  logic [W-1:0]     d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  logic [DEPTH-1:0] adv;
  logic             room;
  logic [W-1:0]     rev_data;
  logic             accept;
  logic             deliver;

  // Advance chain, walked from the output side. "room" means the stage
  // downstream of the one being examined can take a beat this cycle: it is
  // either empty or its own occupant is moving on.
  always_comb begin
    adv  = '0;
    room = out_ready && !flush;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      adv[s] = v_q[s] && room;
      room   = !v_q[s] || room;
    end
  end

  always_comb begin
    rev_data = '0;
    for (int k = 0; k < LANES; k++) begin
      rev_data[k*LANE_W +: LANE_W] = in_data[(LANES-1-k)*LANE_W +: LANE_W];
    end
  end

  assign in_ready  = !flush && room;
  assign out_valid = v_q[DEPTH-1] && !flush;
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  always_comb begin
    v_d    = v_q;
    d_d    = d_q;
    v_d[0] = accept || (v_q[0] && !adv[0]);
    d_d[0] = accept ? (in_rev ? rev_data : in_data) : d_q[0];
    for (int s = 1; s < DEPTH; s++) begin
      v_d[s] = adv[s-1] || (v_q[s] && !adv[s]);
      d_d[s] = adv[s-1] ? d_q[s-1] : d_q[s];
    end
    count_d = count_q + CW'(accept) - CW'(deliver);
    if (flush) begin
      v_d     = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        d_q[s] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int s = 0; s < DEPTH; s++) begin
        d_q[s] <= d_d[s];
      end
    end
  end

endmodule

// File: tb/tb_gen_pipe.sv
// tb/tb_gen_pipe.sv - scoreboard bench for gen_pipe

module tb_gen_pipe;

  localparam int LANES  = 4;
  localparam int LANE_W = 2;
  localparam int DEPTH  = 3;
  localparam int W      = LANES * LANE_W;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int NCYC   = 400;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_rev;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;

  gen_pipe #(.LANES(LANES), .LANE_W(LANE_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rev(in_rev), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           vis;
  } beat_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    edge_n = 0;
  bit    mon_on = 0;
  int    exp_deliv = 0;
  int    dut_deliv = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [W-1:0] lane_rev(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[k*LANE_W +: LANE_W] = d[(LANES-1-k)*LANE_W +: LANE_W];
    return r;
  endfunction

  // Monitor: a beat is on the output once it has aged DEPTH-1 edges and its
  // predecessor has left; it stays there until a cycle with out_ready=1.
  always @(negedge clk) begin
    if (mon_on) begin
      bit exp_v;
      #1;
      exp_v = (q.size() > 0) && (q[0].vis <= edge_n) && !flush;
      chk("out_valid", out_valid, exp_v);
      if (exp_v) chk("out_data", out_data, q[0].data);
      if (out_valid && out_ready) dut_deliv++;
      if (exp_v && out_ready) begin
        void'(q.pop_front());
        exp_deliv++;
        if (q.size() > 0 && q[0].vis < edge_n + 1) q[0].vis = edge_n + 1;
      end
    end
  end

  logic [W-1:0] dir_data [3];
  logic         dir_rev  [3];

  initial begin
    dir_data[0] = 8'b11_10_01_00; dir_rev[0] = 1'b1;
    dir_data[1] = 8'b11_10_01_00; dir_rev[1] = 1'b0;
    dir_data[2] = 8'b10_10_10_10; dir_rev[2] = 1'b1;

    reset = 1'b0; flush = 1'b0; out_ready = 1'b1; in_rev = 1'b0;
    in_valid = 1'b1; in_data = W'($urandom);
    repeat (3) begin
      @(posedge clk); #1;
      in_data = W'($urandom);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    mon_on = 1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      bit exp_rdy;
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = W'($urandom);
      in_rev   = 1'($urandom);
      flush    = (cyc > 30) && (cyc < NCYC - 20) && ($urandom_range(0, 15) == 0);
      if (cyc < 3) begin
        in_valid = 1'b1; in_data = dir_data[cyc]; in_rev = dir_rev[cyc];
      end
      if (cyc < 10) begin
        in_valid = 1'b1; out_ready = 1'b1;
      end else if (cyc < 22) begin
        in_valid = 1'b1; out_ready = 1'b0;
      end else if (cyc >= NCYC - 10) begin
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      end else begin
        out_ready = ($urandom_range(0, 2) != 0);
      end

      if (cyc == 150) begin
        #1 reset = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_count", count, 0);
        chk("async_out_data", out_data, 0);
        #1 reset = 1'b1;
        q.delete();
      end

      @(negedge clk);
      chk("count", count, q.size());
      exp_rdy = !flush && ((q.size() < DEPTH) || out_ready);
      chk("in_ready", in_ready, exp_rdy);
      if (flush) begin
        q.delete();
      end else if (in_valid && exp_rdy) begin
        beat_t b;
        b.data = in_rev ? lane_rev(in_data) : in_data;
        b.vis  = edge_n + DEPTH;
        q.push_back(b);
      end
    end

    @(posedge clk); #1;
    mon_on = 0;
    chk("deliveries", dut_deliv, exp_deliv);
    chk("drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
